// File: rtl/fp_mult_sched.sv
// Round-robin scheduler sharing one pipelined fp_mult between N requesters.
// A requester-ID tag pipeline matched to the multiplier latency routes each product back to its issuer.
`timescale 1ns/1ps
module fp_mult_sched #(
  parameter int N    = 2,
  parameter int ID_W = 1,
  parameter int LAT  = 3,
  localparam int CNT_W = $clog2(LAT + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [31:0]       mult_a,
  output logic [31:0]       mult_b,
  input  logic [31:0]       mult_y,
  output logic              resp_valid,
  output logic [ID_W-1:0]   resp_id,
  output logic [31:0]       resp_y,
  output logic [CNT_W-1:0]  in_flight
);

  logic [ID_W-1:0] r_rr_ptr;
  logic [LAT:0]    r_tag_v;
  logic [ID_W-1:0] r_tag_id [LAT+1];

  logic            w_found;
  logic            w_issue;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_next_ptr;
  logic [N-1:0]    w_grant;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % N;
  endfunction

  // Handshake: an operand pair is taken at the edge where req_valid[i] & req_ready[i];
  // ready is a pure function of valid and the round-robin pointer, and results carry no backpressure.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_grant  = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req_valid[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'(wrap_idx(int'(r_rr_ptr), k));
        w_grant[wrap_idx(int'(r_rr_ptr), k)] = 1'b1;
        w_sel_a  = req_a[32*wrap_idx(int'(r_rr_ptr), k) +: 32];
        w_sel_b  = req_b[32*wrap_idx(int'(r_rr_ptr), k) +: 32];
      end
    end
    w_next_ptr = ID_W'((int'(w_gnt_id) + 1) % N);
  end

  assign w_issue   = w_found & ~rst;
  assign req_ready = rst ? '0 : w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= '0;
      in_flight  <= '0;
      r_rr_ptr   <= '0;
      r_tag_v    <= '0;
      for (int k = 0; k <= LAT; k++) r_tag_id[k] <= '0;
    end else begin
      if (w_issue) begin
        mult_a   <= w_sel_a;
        mult_b   <= w_sel_b;
        r_rr_ptr <= w_next_ptr;
      end
      r_tag_v     <= {r_tag_v[LAT-1:0], w_issue};
      r_tag_id[0] <= w_gnt_id;
      for (int k = 1; k <= LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
      // The final tag stage lines up with the product for that issue on mult_y.
      if (r_tag_v[LAT]) begin
        resp_valid <= 1'b1;
        resp_id    <= r_tag_id[LAT];
        resp_y     <= mult_y;
      end else begin
        resp_valid <= 1'b0;
      end
      case ({w_issue, r_tag_v[LAT]})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
